// File: rtl/seg_scan_if.sv
// Bus between the game logic and the display scan controller.
// The game logic (master) posts BCD digits and the leading-zero enable;
// the controller (slave) returns the handshake pulses and the digit drive.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    lz_en;
    logic                    load_ack;
    logic                    frame_done;
    logic [3:0]              bcd;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output digits_in, load, lz_en,
        input  load_ack, frame_done, bcd, blank, an
    );

    modport slave (
        input  digits_in, load, lz_en,
        output load_ack, frame_done, bcd, blank, an
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Each digit slot is PRESCALE clocks: BLANK_CYCLES with everything off, then
// the digit itself. New digits are staged and only copied into the visible
// shadow register at the end of a full scan, so a frame is never mixed.
// All outputs are registered and computed from the next-state values so that
// they line up with the state they describe.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Digit k (k>0) is suppressed when it and every more significant digit are zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [DW-1:0] digs,
        input logic          en
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  nz;
        m  = '0;
        nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz   = nz | (digs[4*k +: 4] != 4'd0);
            m[k] = en & (k != 0) & ~nz;
        end
        return m;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         staging_q, staging_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  blank_q, blank_d;
    logic [3:0]            bcd_q, bcd_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary_s;
    logic                  boundary_next_s;
    logic [NUM_DIGITS-1:0] supp_s;
    logic [3:0]            digit_s;

    // Next-state for scan position, staging/shadow handshake and output drive.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        staging_d    = staging_q;
        pending_d    = pending_q;
        an_d         = '1;
        blank_d      = 1'b1;
        bcd_d        = bcd_q;
        load_ack_d   = 1'b0;
        frame_done_d = 1'b0;

        boundary_s = (state_q == ST_SHOW) && (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_BLANK;
                    if (idx_q == IDX_MAX) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_SHOW;
                end
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase

        // The boundary consumes the old staging before a same-cycle load refills it.
        if (boundary_s && pending_q) begin
            shadow_d = staging_q;
        end else begin
            shadow_d = shadow_q;
        end

        if (bus.load) begin
            staging_d = bus.digits_in;
            pending_d = 1'b1;
        end else if (boundary_s) begin
            staging_d = staging_q;
            pending_d = 1'b0;
        end else begin
            staging_d = staging_q;
            pending_d = pending_q;
        end

        boundary_next_s = (state_d == ST_SHOW) && (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);
        supp_s          = lz_mask(shadow_d, bus.lz_en);
        digit_s         = shadow_d[{idx_d, 2'b00} +: 4];

        if (state_d == ST_SHOW) begin
            bcd_d = digit_s;
            if (!supp_s[idx_d]) begin
                an_d[idx_d] = 1'b0;
                blank_d     = 1'b0;
            end else begin
                blank_d = 1'b1;
            end
        end else begin
            bcd_d = bcd_q;
        end

        frame_done_d = boundary_next_s;
        load_ack_d   = boundary_next_s & pending_d;
    end

    // Scan state, handshake storage and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            staging_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            blank_q      <= 1'b1;
            bcd_q        <= 4'd0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            staging_q    <= staging_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            blank_q      <= blank_d;
            bcd_q        <= bcd_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.blank      = blank_q;
    assign bus.bcd        = bcd_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
// The stimulus task predicts each cycle's outputs from a cycle-count model of
// the display and queues them; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;
    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    typedef struct packed {
        logic [3:0] an;
        logic       blank;
        logic [3:0] bcd;
        logic       ack;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .PRESCALE    (P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t exp_q[$];
    int   cyc_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // model state
    int          m_c;
    logic [15:0] m_shadow;
    logic [15:0] m_staging;
    bit          m_pending;
    bit          m_lz;
    logic [3:0]  m_bcd;
    int          cyc_total = 0;
    bit          cur_lz = 1'b0;

    function automatic bit at_boundary();
        return ((m_c % P) == P - 1) && (((m_c / P) % N) == N - 1);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   pos, dig;
        logic [15:0] upper;
        pos   = m_c % P;
        dig   = (m_c / P) % N;
        upper = m_shadow >> (4 * dig);
        e.fd  = at_boundary();
        e.ack = at_boundary() && m_pending;
        if (pos < B) begin
            e.an    = 4'hF;
            e.blank = 1'b1;
            e.bcd   = m_bcd;
        end else begin
            e.bcd = upper[3:0];
            if (m_lz && dig > 0 && upper == 16'h0000) begin
                e.an    = 4'hF;
                e.blank = 1'b1;
            end else begin
                e.an    = 4'hF & ~(4'h1 << dig);
                e.blank = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic step(input bit rst, input bit ld, input logic [15:0] dig, input bit lz);
        exp_t e;
        e = model_out();
        exp_q.push_back(e);
        cyc_q.push_back(cyc_total);
        rst_n         = rst;
        bus.load      = ld;
        bus.digits_in = dig;
        bus.lz_en     = lz;
        if (!rst) begin
            m_c       = 0;
            m_shadow  = 16'h0000;
            m_staging = 16'h0000;
            m_pending = 1'b0;
            m_bcd     = 4'd0;
        end else begin
            if (e.fd && m_pending) begin
                m_shadow  = m_staging;
                m_pending = 1'b0;
            end
            if (ld) begin
                m_staging = dig;
                m_pending = 1'b1;
            end
            m_bcd = e.bcd;
            m_c++;
        end
        m_lz = lz;
        @(posedge clk);
        #1;
        cyc_total++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, cur_lz);
    endtask

    task automatic load_run(input logic [15:0] d, input int n);
        step(1'b1, 1'b1, d, cur_lz);
        idle(n);
    endtask

    // Monitor: compare DUT outputs against the queued prediction each cycle.
    exp_t mon_e, mon_got;
    int   mon_c;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_c   = cyc_q.pop_front();
            mon_got = {bus.an, bus.blank, bus.bcd, bus.load_ack, bus.frame_done};
            vectors++;
            if (mon_got !== mon_e) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got an=%b blank=%b bcd=%h ack=%b fd=%b, expected an=%b blank=%b bcd=%h ack=%b fd=%b",
                         mon_c, mon_got.an, mon_got.blank, mon_got.bcd, mon_got.ack, mon_got.fd,
                         mon_e.an, mon_e.blank, mon_e.bcd, mon_e.ack, mon_e.fd);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = 16'h0000;
        bus.lz_en     = 1'b0;
        m_c       = 0;
        m_shadow  = 16'h0000;
        m_staging = 16'h0000;
        m_pending = 1'b0;
        m_lz      = 1'b0;
        m_bcd     = 4'd0;
        @(posedge clk);
        #1;

        // reset held, then free-run with all zeros
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        idle(70);

        // plain load without blanking
        load_run(16'h1234, 80);

        // leading-zero blanking
        cur_lz = 1'b1;
        load_run(16'h0050, 70);
        load_run(16'h0000, 70);
        load_run(16'h0300, 70);
        cur_lz = 1'b0;

        // overwrite before a boundary
        load_run(16'h1111, 4);
        load_run(16'h2222, 70);

        // load landing exactly on a boundary with another load pending
        load_run(16'h1111, 70);
        step(1'b1, 1'b1, 16'h3333, cur_lz);
        for (int i = 0; i < 4 * P && !at_boundary(); i++) idle(1);
        step(1'b1, 1'b1, 16'h4444, cur_lz);
        idle(70);

        // reset in the middle of digit 2 with a load outstanding
        step(1'b1, 1'b1, 16'h5555, cur_lz);
        for (int i = 0; i < 4 * P && !((((m_c / P) % N) == 2) && ((m_c % P) >= B + 1)); i++) idle(1);
        step(1'b0, 1'b0, 16'h0000, cur_lz);
        idle(70);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst, ld;
            logic [15:0] d;
            rst = ($urandom_range(0, 499) != 0);
            ld  = ($urandom_range(0, 15) == 0);
            d   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
            if ($urandom_range(0, 7) == 0) cur_lz = ~cur_lz;
            step(rst, ld, d, cur_lz);
        end

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the score display on the CPLD.
- Drives a single shared SevenSeg BCD decoder across NUM_DIGITS common-anode digits, one digit at a time, with an inter-digit blanking gap to suppress ghosting.
- Game logic posts new score digits through a load/ack handshake. New values are applied only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; index 0 is least significant.
- PRESCALE, 1000, clocks per digit slot, including the blank gap.
- BLANK_CYCLES, 16, clocks at the start of each slot with all digits off.
- Legal values: 1 <= BLANK_CYCLES < PRESCALE; NUM_DIGITS >= 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset: synchronous to clk, active-low.
- digits_in  in  4*NUM_DIGITS  BCD digits; nibble k is digit k.
- load  in  1  single-cycle strobe that captures digits_in into staging.
- lz_en  in  1  leading-zero blanking enable; sampled every cycle.
- load_ack  out  1  one-cycle pulse when staged digits become visible.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- bcd  out  4  digit value to the SevenSeg decoder input.
- blank  out  1  1 = segments forced off downstream of the decoder.
- an  out  NUM_DIGITS  digit enables, active-low; only one bit is low at a time.

Behaviour:
- Reset (rst_n=0 at a clk edge), effective the following cycle:
  - state=BLANK, idx=0, slot counter=0
  - an all ones, blank=1, bcd=0, load_ack=0, frame_done=0
  - shadow=0, staging=0, pending=0
- Reset mid-frame aborts the frame. No load_ack is issued for a discarded pending load.
- The slot counter runs 0..PRESCALE-1, is $clog2(PRESCALE) bits wide, and wraps to 0.
- State BLANK (counter 0..BLANK_CYCLES-1):
  - an all ones, blank=1, bcd holds its last value.
  - At counter=BLANK_CYCLES-1, go to SHOW.
- State SHOW (counter BLANK_CYCLES..PRESCALE-1):
  - bcd=shadow[idx].
  - Digit lit: an[idx]=0, other an bits 1, blank=0.
  - Digit suppressed: an all ones, blank=1.
  - At counter=PRESCALE-1, go to BLANK and idx advances.
- idx advance: idx+1, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary = the cycle with SHOW, counter=PRESCALE-1, idx=NUM_DIGITS-1. In that cycle:
  - frame_done=1.
  - If pending=1: shadow<=staging, load_ack=1, pending<=0.
- Load:
  - load=1 sets staging<=digits_in and pending<=1.
  - Repeated loads before a boundary overwrite staging; exactly one load_ack is issued.
- Load coinciding with a boundary:
  - The boundary applies the old staging if pending was 1.
  - The new digits_in still go to staging, and pending ends at 1.
  - The new value is applied at the next boundary.
- Leading-zero suppression, when lz_en=1:
  - Digit k (k>0) is suppressed iff shadow[j]==0 for all j>=k.
  - Digit 0 is never suppressed.
  - When lz_en=0, no digit is suppressed.
- Values 10..15 are passed through to bcd unchanged; the decoder renders them as hex.
- load_ack and frame_done are registered and high for exactly one cycle.
- Frame period is NUM_DIGITS*PRESCALE clocks.
- First boundary after reset: cycle NUM_DIGITS*PRESCALE-1, counted from the first cycle with rst_n=1.

Test Plan:
(All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2; frame = 32 cycles.)
1. Reset: hold rst_n=0 for 3 clocks, then release.
   - While in reset: an=4'b1111, blank=1, bcd=0, load_ack=0.
   - frame_done first pulses 31 cycles after release and then every 32 cycles.
   - All digits show 0 with an one-hot low.
2. Load, lz_en=0: pulse load with digits_in=16'h1234.
   - load_ack coincides with the next frame_done.
   - Next frame: 2 cycles an=1111; 6 cycles an=1110, bcd=4.
   - Then 2 blank; 6 cycles an=1101, bcd=3; then bcd=2 (an=1011); then bcd=1 (an=0111).
3. Leading-zero blanking, lz_en=1:
   - Load 16'h0050: digit slots 3 and 2 give blank=1, an=1111; digit 1 shows 5; digit 0 shows 0.
   - Load 16'h0000: only digit 0 lit, showing 0.
   - Load 16'h0300: digits 2, 1, 0 lit.
4. Overwrite: load 16'h1111, then 5 cycles later 16'h2222, both before a boundary.
   - Exactly one load_ack.
   - Following frame shows 2,2,2,2.
5. Load on boundary: shadow=16'h1111, staging 16'h3333 pending; assert load with 16'h4444 in the frame_done cycle.
   - That cycle: load_ack=1; the next frame shows 3s.
   - The next boundary gives a second load_ack; the frame after shows 4s.
6. Reset mid-operation: pending load outstanding; assert rst_n=0 for one cycle during SHOW of idx=2.
   - Next cycle: an=1111, blank=1, idx=0, shadow=0.
   - No load_ack for the discarded load; frame timing restarts from release.
